// File: rtl/dmux_pkg.sv
// Shared definitions for the 16-bit streaming demultiplexer: default sizes
// and the channel-select encoding.
package dmux_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int DEPTH_DEF = 2;
    localparam int CNT_W_DEF = 16;

    typedef enum logic {
        CH_A = 1'b0,
        CH_B = 1'b1
    } dmux_ch_t;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int occ_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dmux_chan_fifo.sv
// Per-channel FIFO: circular buffer with occupancy count. The head word and
// status flags come straight from registered state.
module dmux_chan_fifo
    import dmux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int OCC_W = occ_bits(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic             full,
    output logic [OCC_W-1:0] count_out
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses a push even if it pops in the same cycle; an empty
    // one ignores pop.
    assign do_push = push & ~full;
    assign do_pop  = pop & valid;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head      = mem[rd_ptr];
    assign valid     = (count != '0);
    assign full      = (count == OCC_W'(DEPTH));
    assign count_out = count;

endmodule

// File: rtl/dmux_16_stream.sv
// Streaming 1:2 word demultiplexer with a small FIFO per channel, so a stalled
// consumer never blocks the other, plus per-channel delivered-word counters.
module dmux_16_stream
    import dmux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    localparam int OCC_W = occ_bits(DEPTH);

    dmux_ch_t         sel;
    logic             full_a;
    logic             full_b;
    logic [OCC_W-1:0] occ_a;
    logic [OCC_W-1:0] occ_b;
    logic             push_a;
    logic             push_b;

    assign sel = dmux_ch_t'(in_sel);

    // Ready depends only on the select and registered occupancy; consumer
    // ready signals deliberately have no path here.
    assign in_ready = (sel == CH_B) ? (occ_b != OCC_W'(DEPTH))
                                    : (occ_a != OCC_W'(DEPTH));

    assign push_a = in_valid & (sel == CH_A) & ~full_a;
    assign push_b = in_valid & (sel == CH_B) & ~full_b;

    dmux_chan_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .OCC_W (OCC_W)
    ) u_chan_a (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push_a),
        .push_data (in_data),
        .pop       (a_ready),
        .head      (a_data),
        .valid     (a_valid),
        .full      (full_a),
        .count_out (occ_a)
    );

    dmux_chan_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .OCC_W (OCC_W)
    ) u_chan_b (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push_b),
        .push_data (in_data),
        .pop       (b_ready),
        .head      (b_data),
        .valid     (b_valid),
        .full      (full_b),
        .count_out (occ_b)
    );

    // Delivery counters wrap freely at 2^CNT_W.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            a_count <= '0;
            b_count <= '0;
        end else begin
            if (a_valid && a_ready) begin
                a_count <= a_count + 1'b1;
            end
            if (b_valid && b_ready) begin
                b_count <= b_count + 1'b1;
            end
        end
    end

endmodule
